counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl_if.sv | 39 +++
 rtl/counter_ctrl.sv | 121 ++++++++++++
 tb/tb_counter_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if -- control/status bundle for counter_ctrl.
//
// Signals
//   start       : request to begin a count run
//   stop        : abort the current run
//   pause       : freeze the count while high
//   auto_reload : 1 = periodic, 0 = one-shot (captured when a start is accepted)
//   limit       : terminal count (captured when a start is accepted)
//   q           : current count value (registered)
//   busy        : high while a run is in progress (RUN or PAUSED)
//   done        : one-cycle terminal-count pulse (registered)
//   state       : FSM state, IDLE=00 RUN=01 PAUSED=10 DONE=11
//
// Modports
//   master : the controller side that drives commands and observes status
//   slave  : the counter side (counter_ctrl)
interface counter_ctrl_if #(
  parameter int WIDTH = 4
) ();
  logic             start;
  logic             stop;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  modport master (
    output start, stop, pause, auto_reload, limit,
    input  q, busy, done, state
  );

  modport slave (
    input  start, stop, pause, auto_reload, limit,
    output q, busy, done, state
  );
endinterface

// File: rtl/counter_ctrl.sv
// counter_ctrl -- start/stop/pause sequenced counter with one-shot or
// periodic terminal count.
//
// Ports
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high reset
//   bus   : counter_ctrl_if.slave (commands in, q/busy/done/state out)
//
// Handshake: there is no valid/ready pair. A start is accepted on any rising
// edge where the FSM is in IDLE or DONE, start=1 and stop=0; at that edge the
// limit and auto_reload inputs are captured and the run begins at q=0. start
// is ignored in RUN and PAUSED; stop aborts a run; pause freezes it.
//
// Per-cycle priority: reset > stop > pause > terminal detect > increment.
//
// All outputs come straight from flops, so downstream logic sees clean,
// glitch-free status. The state output doubles as the FSM debug view.
module counter_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  counter_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] limit_q;
  logic             reload_q;
  logic             done_q;
  logic             busy_q;

  logic start_ok;
  logic at_limit;

  // stop blocks a start even in IDLE/DONE.
  assign start_ok = bus.start && !bus.stop;
  // Compared against the captured limit, so mid-run changes on the limit
  // input cannot shorten or extend the current run.
  assign at_limit = (count_q == limit_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      limit_q  <= '0;
      reload_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the terminal branch re-raises it.
      done_q <= 1'b0;

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state_q  <= ST_RUN;
            count_q  <= '0;
            limit_q  <= bus.limit;
            reload_q <= bus.auto_reload;
            busy_q   <= 1'b1;
          end else if (state_q == ST_DONE) begin
            // DONE lasts one cycle; q keeps showing the terminal value.
            state_q <= ST_IDLE;
          end
        end

        ST_RUN: begin
          if (bus.stop) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
          end else if (bus.pause) begin
            // Pausing pre-empts terminal detect for this cycle.
            state_q <= ST_PAUSED;
          end else if (at_limit) begin
            done_q <= 1'b1;
            if (reload_q) begin
              count_q <= '0;
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
            end
          end else begin
            count_q <= count_q + WIDTH'(1);
          end
        end

        ST_PAUSED: begin
          if (bus.stop) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
          end else if (!bus.pause) begin
            // Resume edge only re-enters RUN; counting restarts next edge.
            state_q <= ST_RUN;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          count_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q     = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl -- self-checking bench for counter_ctrl.
// A driver applies one set of inputs per cycle on the falling edge and pushes
// the reference model's expected post-edge outputs into exp_q; a monitor pops
// one entry after every rising edge and compares it with q/state/busy/done.
module tb_counter_ctrl;
  localparam int WIDTH = 4;
  localparam int W     = WIDTH + 4;

  logic clk;
  logic reset;

  counter_ctrl_if #(.WIDTH(WIDTH)) bus ();

  counter_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: state codes 0=IDLE 1=RUN 2=PAUSED 3=DONE.
  int m_state = 0;
  int m_q     = 0;
  int m_lim   = 0;
  int m_ar    = 0;
  int m_done  = 0;

  function automatic void model_step(input int r, input int s, input int sp,
                                     input int p, input int ar, input int lim);
    m_done = 0;
    if (r != 0) begin
      m_state = 0; m_q = 0; m_lim = 0; m_ar = 0;
    end else if (m_state == 0 || m_state == 3) begin
      if (s != 0 && sp == 0) begin
        m_state = 1; m_q = 0; m_lim = lim; m_ar = ar;
      end else if (m_state == 3) begin
        m_state = 0;
      end
    end else if (sp != 0) begin
      m_state = 0; m_q = 0;
    end else if (m_state == 2) begin
      if (p == 0) m_state = 1;
    end else if (p != 0) begin
      m_state = 2;
    end else if (m_q == m_lim) begin
      m_done = 1;
      if (m_ar != 0) m_q = 0;
      else           m_state = 3;
    end else begin
      m_q = m_q + 1;
    end
  endfunction

  function automatic logic [W-1:0] model_out();
    logic [W-1:0] v;
    v[W-1:4] = WIDTH'(m_q);
    v[3:2]   = 2'(m_state);
    v[1]     = (m_state == 1 || m_state == 2);
    v[0]     = (m_done != 0);
    return v;
  endfunction

  // ---------------------------------------------------------------- driver
  task automatic step(input logic r, input logic s, input logic sp,
                      input logic p, input logic ar, input logic [WIDTH-1:0] lim);
    @(negedge clk);
    reset           = r;
    bus.start       = s;
    bus.stop        = sp;
    bus.pause       = p;
    bus.auto_reload = ar;
    bus.limit       = lim;
    model_step(int'(r), int'(s), int'(sp), int'(p), int'(ar), int'(lim));
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.q, bus.state, bus.busy, bus.done};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs cyc=%0d got q=%0h state=%0h busy=%0h done=%0h required q=%0h state=%0h busy=%0h done=%0h",
                   cyc, a[W-1:4], a[3:2], a[1], a[0], e[W-1:4], e[3:2], e[1], e[0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.pause       = 1'b0;
    bus.auto_reload = 1'b0;
    bus.limit       = '0;

    // Reset two cycles, then one-shot limit=3.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
    idle(7);

    // Periodic limit=2; start held high and limit changed mid-run.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    idle(2);

    // limit=9 with pause held 4 cycles at q=5.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
    idle(5);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    idle(8);

    // limit=12, stop at q=7; then start+stop together in IDLE.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd12);
    idle(7);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5);
    idle(2);

    // Stop while paused.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    idle(1);

    // limit=15, reset pulse at q=10, then limit=0 one-shot.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd15);
    idle(10);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    idle(4);

    // limit=15 periodic across the 15->0 wrap, then restart from DONE.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd15);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
    idle(5);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic r, s, sp, p, ar;
      logic [WIDTH-1:0] lim;
      int sel;
      r   = ($urandom_range(0, 79) == 0);
      s   = ($urandom_range(0, 2) == 0);
      sp  = ($urandom_range(0, 24) == 0);
      p   = ($urandom_range(0, 5) == 0);
      ar  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 5);
      if (sel == 0)      lim = '0;
      else if (sel == 1) lim = '1;
      else               lim = WIDTH'($urandom_range(0, 15));
      step(r, s, sp, p, ar, lim);
    end
    idle(3);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
